hier_node_router: RTL and testbench

- Parametrised hierarchy node with NUM_CHILDREN child ports.
- Routes requests from one parent port to the selected child through a registered stage.
- Arbitrates child responses back to the parent round-robin through a 2-entry output FIFO.
- Tracks outstanding transactions per child with credit limiting. Instances of this node nest to form the design tree.

---
 rtl/hier_node_router.sv | 212 +++++++++++++++++++++
 tb/tb_hier_node_router.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hier_node_router.sv
// hier_node_router: one node of the routing tree.
//   Parent request  : p_req_valid/ready/dest/data -> registered stage -> child selected by dest
//   Child request   : c_req_valid (one-hot), c_req_ready, c_req_data (shared by all children)
//   Child response  : c_rsp_valid, c_rsp_ready (one-hot grant), c_rsp_data (child i at [i*DATA_W +: DATA_W])
//   Parent response : p_rsp_valid/ready/data/src, fed from a 2-entry FIFO
//   Status          : err_dest, err_unexp (sticky until rst), busy
// Each child has an outstanding-request counter. A request is only accepted
// while its target child is below MAX_OUTST, and the credit is reserved when
// the request is accepted.

// Per-child outstanding counter. An increment and a decrement in the same
// cycle cancel. A decrement at zero leaves the count at zero and raises unexp.
module hier_node_credit #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             unexp
);
    assign unexp = dec & (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc & ~dec)
            cnt <= cnt + 1'b1;
        else if (dec & ~inc & (cnt != '0))
            cnt <= cnt - 1'b1;
    end
endmodule

module hier_node_router #(
    parameter  int NUM_CHILDREN = 5,
    parameter  int DATA_W       = 32,
    parameter  int MAX_OUTST    = 4,
    localparam int CHILD_W      = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           p_req_valid,
    output logic                           p_req_ready,
    input  logic [CHILD_W-1:0]             p_req_dest,
    input  logic [DATA_W-1:0]              p_req_data,
    output logic [NUM_CHILDREN-1:0]        c_req_valid,
    input  logic [NUM_CHILDREN-1:0]        c_req_ready,
    output logic [DATA_W-1:0]              c_req_data,
    input  logic [NUM_CHILDREN-1:0]        c_rsp_valid,
    output logic [NUM_CHILDREN-1:0]        c_rsp_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] c_rsp_data,
    output logic                           p_rsp_valid,
    input  logic                           p_rsp_ready,
    output logic [DATA_W-1:0]              p_rsp_data,
    output logic [CHILD_W-1:0]             p_rsp_src,
    output logic                           err_dest,
    output logic                           err_unexp,
    output logic                           busy
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [CHILD_W-1:0] src;
        logic [DATA_W-1:0]  data;
    } rsp_ent_t;

    // ---------------- request stage ----------------
    logic                                 rq_vld;
    logic [CHILD_W-1:0]                   rq_dest;
    logic [DATA_W-1:0]                    rq_data;
    logic                                 dest_invalid, issue, accept;
    logic [NUM_CHILDREN-1:0][CNT_W-1:0]   outst;
    logic [CNT_W-1:0]                     dest_cnt;
    logic [NUM_CHILDREN-1:0]              cr_inc, cr_dec, cr_unexp;
    logic                                 any_outst;

    // Widened compare so that a power-of-two child count has no invalid dest.
    assign dest_invalid = {1'b0, p_req_dest} >= (CHILD_W+1)'(NUM_CHILDREN);
    assign issue        = rq_vld & c_req_ready[rq_dest];
    assign p_req_ready  = (~rq_vld | issue) & (dest_invalid | (dest_cnt < CNT_W'(MAX_OUTST)));
    assign accept       = p_req_valid & p_req_ready;
    assign c_req_data   = rq_data;

    // A mux loop rather than a direct index, because an invalid dest would
    // select past the end of outst.
    always_comb begin
        dest_cnt    = '0;
        any_outst   = 1'b0;
        c_req_valid = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (p_req_dest == CHILD_W'(i))
                dest_cnt = outst[i];
            if (outst[i] != '0)
                any_outst = 1'b1;
        end
        if (rq_vld)
            c_req_valid[rq_dest] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rq_vld  <= 1'b0;
            rq_dest <= '0;
            rq_data <= '0;
        end else if (accept & ~dest_invalid) begin
            rq_vld  <= 1'b1;
            rq_dest <= p_req_dest;
            rq_data <= p_req_data;
        end else if (issue) begin
            rq_vld  <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_child
        assign cr_inc[i] = accept & ~dest_invalid & (p_req_dest == CHILD_W'(i));
        assign cr_dec[i] = c_rsp_valid[i] & c_rsp_ready[i];

        hier_node_credit #(.CNT_W(CNT_W)) u_credit (
            .clk   (clk),
            .rst   (rst),
            .inc   (cr_inc[i]),
            .dec   (cr_dec[i]),
            .cnt   (outst[i]),
            .unexp (cr_unexp[i])
        );
    end

    // ---------------- response arbiter + FIFO ----------------
    rsp_ent_t           fifo_mem [2];
    logic               fifo_wp, fifo_rp;
    logic [1:0]         fifo_cnt;
    logic               push, pop, arb_en;
    logic [CHILD_W-1:0] rr_ptr, gnt_idx;
    logic [DATA_W-1:0]  gnt_data;

    assign pop    = p_rsp_valid & p_rsp_ready;
    // A full FIFO still takes a grant when the head leaves in the same cycle.
    assign arb_en = (fifo_cnt != 2'd2) | pop;

    always_comb begin
        int j;
        push        = 1'b0;
        gnt_idx     = '0;
        gnt_data    = '0;
        c_rsp_ready = '0;
        j           = 0;
        if (arb_en) begin
            for (int k = 0; k < NUM_CHILDREN; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_CHILDREN)
                    j = j - NUM_CHILDREN;
                if (!push && c_rsp_valid[j]) begin
                    push    = 1'b1;
                    gnt_idx = CHILD_W'(j);
                end
            end
        end
        if (push)
            c_rsp_ready[gnt_idx] = 1'b1;
        for (int i = 0; i < NUM_CHILDREN; i++)
            if (gnt_idx == CHILD_W'(i))
                gnt_data = c_rsp_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= 2'd0;
            rr_ptr   <= '0;
        end else begin
            if (push) begin
                fifo_wp <= ~fifo_wp;
                rr_ptr  <= (gnt_idx == CHILD_W'(NUM_CHILDREN - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop)
                fifo_rp <= ~fifo_rp;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage is not reset; the count and pointers qualify it. When full,
    // a push only happens together with a pop and lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wp] <= '{src: gnt_idx, data: gnt_data};
    end

    assign p_rsp_valid = (fifo_cnt != 2'd0);
    assign p_rsp_data  = fifo_mem[fifo_rp].data;
    assign p_rsp_src   = fifo_mem[fifo_rp].src;

    // ---------------- status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_dest  <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            if (accept & dest_invalid)
                err_dest <= 1'b1;
            if (|cr_unexp)
                err_unexp <= 1'b1;
        end
    end

    assign busy = any_outst | rq_vld | (fifo_cnt != 2'd0);
endmodule

// File: tb/tb_hier_node_router.sv
module tb_hier_node_router;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              p_req_valid, p_req_ready;
    logic [CW-1:0]     p_req_dest;
    logic [DW-1:0]     p_req_data;
    logic [N-1:0]      c_req_valid, c_req_ready;
    logic [DW-1:0]     c_req_data;
    logic [N-1:0]      c_rsp_valid, c_rsp_ready;
    logic [N*DW-1:0]   c_rsp_data;
    logic              p_rsp_valid, p_rsp_ready;
    logic [DW-1:0]     p_rsp_data;
    logic [CW-1:0]     p_rsp_src;
    logic              err_dest, err_unexp, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hier_node_router #(.NUM_CHILDREN(N), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst(rst),
        .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
        .p_req_dest(p_req_dest), .p_req_data(p_req_data),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_data(c_req_data),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_data(c_rsp_data),
        .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready),
        .p_rsp_data(p_rsp_data), .p_rsp_src(p_rsp_src),
        .err_dest(err_dest), .err_unexp(err_unexp), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rsp_word(input int i);
        return 32'h0D00_0000 + DW'(i);
    endfunction

    // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_req_valid = 1'b0;
        p_req_dest  = '0;
        p_req_data  = '0;
        c_req_ready = '1;
        c_rsp_valid = '0;
        p_rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) c_rsp_data[i*DW +: DW] = rsp_word(i);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rv;
        logic [CW-1:0] dest;
        logic [DW-1:0] data;
        logic [N-1:0]  rspv;
        logic          e_prr;
        logic [N-1:0]  e_cqv;
        logic [DW-1:0] e_cqd;
        logic [N-1:0]  e_crr;
        logic          e_prv;
        logic [CW-1:0] e_src;
        logic          e_busy;
        logic          e_ed;
        logic          e_eu;
    } vec_t;

    vec_t tbl[12];

    // behavioural reference for the random phase
    typedef struct { int src; logic [DW-1:0] data; } ent_t;
    int             m_outst[N];
    bit             m_rqv, m_ed, m_eu;
    int             m_rqd, m_ptr;
    logic [DW-1:0]  m_rqdata;
    ent_t           m_q[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_outst[i] = 0;
        m_rqv = 0; m_ed = 0; m_eu = 0; m_rqd = 0; m_ptr = 0; m_rqdata = '0;
        m_q.delete();
    endtask

    initial begin
        logic [N-1:0]  pend;
        logic [N-1:0]  order [3];
        ent_t          got[$];
        bit            any;

        // {rv, dest, data, rspv, e_prr, e_cqv, e_cqd, e_crr, e_prv, e_src, e_busy, e_ed, e_eu}
        tbl[0]  = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 32'hA5A5_0001, 5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,            5'b00000, 1, 5'b01000, 32'hA5A5_0001, 5'b00000, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0,            5'b01000, 1, 5'b00000, 0,            5'b01000, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 1, 3, 1, 0, 0};
        tbl[6]  = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 7, 32'h0000_0777, 5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0,            5'b00010, 1, 5'b00000, 0,            5'b00010, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 1, 1, 1, 1, 1};
        tbl[11] = '{0, 0, 0,            5'b00000, 1, 5'b00000, 0,            5'b00000, 0, 0, 0, 1, 1};

        // ---- table: reset, single request, single response, error flags ----
        do_reset();
        for (int r = 0; r < 12; r++) begin
            idle();
            p_req_valid = tbl[r].rv;
            p_req_dest  = tbl[r].dest;
            p_req_data  = tbl[r].data;
            c_rsp_valid = tbl[r].rspv;
            #2;
            chk($sformatf("tbl%0d p_req_ready", r), 64'(p_req_ready), 64'(tbl[r].e_prr));
            chk($sformatf("tbl%0d c_req_valid", r), 64'(c_req_valid), 64'(tbl[r].e_cqv));
            if (tbl[r].e_cqv != '0)
                chk($sformatf("tbl%0d c_req_data", r), 64'(c_req_data), 64'(tbl[r].e_cqd));
            chk($sformatf("tbl%0d c_rsp_ready", r), 64'(c_rsp_ready), 64'(tbl[r].e_crr));
            chk($sformatf("tbl%0d p_rsp_valid", r), 64'(p_rsp_valid), 64'(tbl[r].e_prv));
            if (tbl[r].e_prv) begin
                chk($sformatf("tbl%0d p_rsp_src", r), 64'(p_rsp_src), 64'(tbl[r].e_src));
                chk($sformatf("tbl%0d p_rsp_data", r), 64'(p_rsp_data), 64'(rsp_word(int'(tbl[r].e_src))));
            end
            chk($sformatf("tbl%0d busy", r), 64'(busy), 64'(tbl[r].e_busy));
            chk($sformatf("tbl%0d err_dest", r), 64'(err_dest), 64'(tbl[r].e_ed));
            chk($sformatf("tbl%0d err_unexp", r), 64'(err_unexp), 64'(tbl[r].e_eu));
            next();
        end

        // ---- reset clears sticky flags ----
        do_reset();
        #2;
        chk("rst err_dest", 64'(err_dest), 64'd0);
        chk("rst err_unexp", 64'(err_unexp), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst p_req_ready", 64'(p_req_ready), 64'd1);
        next();

        // ---- credit limit on child 2 ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            p_req_valid = 1; p_req_dest = 2; p_req_data = 32'h2000_0000 + DW'(k);
            #2;
            chk($sformatf("cred acc%0d p_req_ready", k), 64'(p_req_ready), 64'd1);
            if (k > 0) begin
                chk($sformatf("cred acc%0d c_req_valid", k), 64'(c_req_valid), 64'(5'b00100));
                chk($sformatf("cred acc%0d c_req_data", k), 64'(c_req_data), 64'(32'h2000_0000 + DW'(k - 1)));
            end
            next();
        end
        idle(); p_req_valid = 1; p_req_dest = 2;
        #2;
        chk("cred 5th p_req_ready", 64'(p_req_ready), 64'd0);
        chk("cred 5th c_req_valid", 64'(c_req_valid), 64'(5'b00100));
        next();
        idle(); p_req_valid = 1; p_req_dest = 0; p_req_data = 32'h0000_0C00;
        #2;
        chk("cred child0 p_req_ready", 64'(p_req_ready), 64'd1);
        next();
        idle(); p_req_valid = 1; p_req_dest = 2; c_rsp_valid = 5'b00100;
        #2;
        chk("cred rsp-cycle p_req_ready", 64'(p_req_ready), 64'd0);
        chk("cred rsp-cycle c_rsp_ready", 64'(c_rsp_ready), 64'(5'b00100));
        chk("cred rsp-cycle c_req_valid", 64'(c_req_valid), 64'(5'b00001));
        next();
        idle(); p_req_valid = 1; p_req_dest = 2; p_req_data = 32'h2000_00FF;
        #2;
        chk("cred after-rsp p_req_ready", 64'(p_req_ready), 64'd1);
        next();
        idle();
        #2;
        chk("cred after-rsp c_req_valid", 64'(c_req_valid), 64'(5'b00100));
        chk("cred after-rsp c_req_data", 64'(c_req_data), 64'(32'h2000_00FF));
        next();

        // ---- round-robin over children 0,1,4 ----
        order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b10000;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            idle(); c_rsp_valid = 5'b10011;
            #2;
            chk($sformatf("rr%0d c_rsp_ready", k), 64'(c_rsp_ready), 64'(order[k % 3]));
            if (k > 0) begin
                chk($sformatf("rr%0d p_rsp_valid", k), 64'(p_rsp_valid), 64'd1);
                chk($sformatf("rr%0d p_rsp_src", k), 64'(p_rsp_src), 64'($clog2(order[(k - 1) % 3])));
            end
            next();
        end

        // ---- backpressure: FIFO fills to 2, holds, then drains in RR order ----
        do_reset();
        pend = 5'b10011;
        for (int k = 0; k < 5; k++) begin
            idle(); p_rsp_ready = 0; c_rsp_valid = pend;
            #2;
            chk($sformatf("bp%0d c_rsp_ready", k), 64'(c_rsp_ready), 64'(k < 2 ? order[k] : 5'b00000));
            if (k > 0) begin
                chk($sformatf("bp%0d p_rsp_valid", k), 64'(p_rsp_valid), 64'd1);
                chk($sformatf("bp%0d p_rsp_data hold", k), 64'(p_rsp_data), 64'(rsp_word(0)));
            end
            pend = pend & ~c_rsp_ready;
            next();
        end
        got.delete();
        for (int k = 0; k < 10; k++) begin
            idle(); p_rsp_ready = 1; c_rsp_valid = pend;
            #2;
            if (p_rsp_valid) got.push_back('{int'(p_rsp_src), p_rsp_data});
            pend = pend & ~c_rsp_ready;
            next();
        end
        chk("bp drained count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp drain0 src", 64'(got[0].src), 64'd0);
            chk("bp drain1 src", 64'(got[1].src), 64'd1);
            chk("bp drain2 src", 64'(got[2].src), 64'd4);
            chk("bp drain2 data", 64'(got[2].data), 64'(rsp_word(4)));
        end

        // ---- randomized traffic vs reference model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit inv, issue, pop, acc, e_prr, e_busy;
            int g, j;
            if (cyc == 1500) begin
                do_reset();
                model_reset();
                #2;
                chk("rnd midreset busy", 64'(busy), 64'd0);
                chk("rnd midreset p_rsp_valid", 64'(p_rsp_valid), 64'd0);
                next();
            end
            p_req_valid = 1'($urandom_range(0, 1));
            p_req_dest  = CW'($urandom_range(0, 7));
            p_req_data  = $urandom;
            c_req_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                c_rsp_valid[i] = ($urandom_range(0, 3) == 0);
                c_rsp_data[i*DW +: DW] = $urandom;
            end
            p_rsp_ready = ($urandom_range(0, 9) < 7);
            #2;
            inv   = (int'(p_req_dest) >= N);
            issue = m_rqv && c_req_ready[m_rqd];
            e_prr = (!m_rqv || issue) && (inv ? 1'b1 : (m_outst[int'(p_req_dest)] < MO));
            pop   = (m_q.size() > 0) && p_rsp_ready;
            g = -1;
            if (m_q.size() < 2 || pop)
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && c_rsp_valid[j]) g = j;
                end
            e_busy = m_rqv || (m_q.size() > 0);
            for (int i = 0; i < N; i++) if (m_outst[i] > 0) e_busy = 1;

            chk("rnd p_req_ready", 64'(p_req_ready), 64'(e_prr));
            chk("rnd c_req_valid", 64'(c_req_valid), m_rqv ? 64'(1) << m_rqd : 64'd0);
            if (m_rqv) chk("rnd c_req_data", 64'(c_req_data), 64'(m_rqdata));
            chk("rnd c_rsp_ready", 64'(c_rsp_ready), g >= 0 ? 64'(1) << g : 64'd0);
            chk("rnd p_rsp_valid", 64'(p_rsp_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("rnd p_rsp_src", 64'(p_rsp_src), 64'(m_q[0].src));
                chk("rnd p_rsp_data", 64'(p_rsp_data), 64'(m_q[0].data));
            end
            chk("rnd busy", 64'(busy), 64'(e_busy));
            chk("rnd err_dest", 64'(err_dest), 64'(m_ed));
            chk("rnd err_unexp", 64'(err_unexp), 64'(m_eu));

            // advance model by one clock
            acc = p_req_valid && e_prr;
            if (acc && inv) m_ed = 1;
            for (int i = 0; i < N; i++) begin
                bit inc, dec;
                inc = acc && !inv && (int'(p_req_dest) == i);
                dec = (g == i);
                if (dec && m_outst[i] == 0) m_eu = 1;
                if (inc && !dec) m_outst[i]++;
                else if (dec && !inc && m_outst[i] > 0) m_outst[i]--;
            end
            if (acc && !inv) begin
                m_rqv = 1; m_rqd = int'(p_req_dest); m_rqdata = p_req_data;
            end else if (issue) begin
                m_rqv = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back('{g, c_rsp_data[g*DW +: DW]});
                m_ptr = (g + 1) % N;
            end
            next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
